// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundle of requester handshake, status and memory-port signals.
// Latency: none, pure wiring.
// Backpressure: n/a; the arbiter holds requesters off by withholding ack.
// Ports (signals): req/lock/we[1:0], addr0/addr1, wdata0/wdata1 from requesters;
//   ack/rdata/owner/busy back to requesters; mem_addr/mem_wdata/mem_we/mem_enable
//   to memory and mem_rdata from it; stall0/stall1 wait-cycle counters.
interface mem_bus_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  lock;
  logic [1:0]  we;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [7:0]  wdata0;
  logic [7:0]  wdata1;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        owner;
  logic        busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_enable;
  logic [7:0]  mem_rdata;
  logic [15:0] stall0;
  logic [15:0] stall1;

  // Arbiter side.
  modport slave (
    input  req, lock, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack, rdata, owner, busy, mem_addr, mem_wdata, mem_we, mem_enable,
           stall0, stall1
  );

  // Requester/memory side.
  modport master (
    output req, lock, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack, rdata, owner, busy, mem_addr, mem_wdata, mem_we, mem_enable,
           stall0, stall1
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 8-bit/16-bit-address memory port between CPU (port 0) and DMA (port 1).
// Latency: grant-to-ack LATENCY+1 cycles; back-to-back one transaction per LATENCY+2 cycles.
// Backpressure: requesters hold req/operands until their one-cycle ack; losers wait in IDLE arbitration.
// Ports: clk, rst_n (async active-low); bus (mem_bus_arbiter_if.slave) carries requester
//   req/lock/we/addr/wdata, ack/rdata/owner/busy, memory mem_* signals and stall0/stall1.
// Optional: define ARB_STALL_COUNT_EN to build saturating per-port wait-cycle counters.
module mem_bus_arbiter #(
  parameter int LATENCY  = 2,  // enable cycles per access, 1..7
  parameter int MAX_LOCK = 4   // consecutive contended locked re-grants, 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        lock_q, lock_d;     // lock of the last granted transaction
  logic        owner_q, owner_d;
  logic        rr_q, rr_d;         // port that wins the next unlocked tie
  logic [3:0]  lock_run_q, lock_run_d;
  logic [7:0]  rdata_q, rdata_d;

  logic grant, winner, contended, keep_lock, busy;

  assign busy = (state_q != IDLE);

  // Arbitration. The lock only holds the bus against a live contender and
  // only while the run stays below MAX_LOCK, so the other port cannot starve.
  always_comb begin
    contended = (bus.req == 2'b11);
    keep_lock = contended && lock_q && bus.req[owner_q] &&
                (lock_run_q < 4'(MAX_LOCK));
    grant     = (state_q == IDLE) && (bus.req != 2'b00);
    if (!contended)     winner = bus.req[1];
    else if (keep_lock) winner = owner_q;
    else                winner = rr_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    lock_run_d = lock_run_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = winner;
          rr_d    = ~winner;
          lock_d  = bus.lock[winner];
          we_d    = bus.we[winner];
          addr_d  = winner ? bus.addr1  : bus.addr0;
          wdata_d = winner ? bus.wdata1 : bus.wdata0;
          // Run counts only contended re-grants; an uncontended locked owner keeps its count.
          if (winner != owner_q || !bus.lock[winner] || (contended && !keep_lock))
            lock_run_d = 4'd0;
          else if (keep_lock)
            lock_run_d = lock_run_q + 4'd1;
          cnt_d   = 3'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(LATENCY - 1)) begin
          if (!we_q) rdata_d = bus.mem_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= 16'd0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      lock_run_q <= 4'd0;
      rdata_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      lock_run_q <= lock_run_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory controls decode from state so they drop the instant reset asserts.
  assign bus.mem_enable = (state_q == ACCESS);
  assign bus.mem_we     = we_q && (state_q == ACCESS);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.ack        = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata      = rdata_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy;

`ifdef ARB_STALL_COUNT_EN
  logic [1:0]  stall_wait;
  logic [15:0] stall0_q, stall1_q;

  // A port waits when it requests but neither owns the bus nor is being granted.
  always_comb begin
    stall_wait[0] = bus.req[0] && !(busy && !owner_q) && !(grant && !winner);
    stall_wait[1] = bus.req[1] && !(busy &&  owner_q) && !(grant &&  winner);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall0_q <= 16'd0;
      stall1_q <= 16'd0;
    end else begin
      if (stall_wait[0] && stall0_q != 16'hFFFF) stall0_q <= stall0_q + 16'd1;
      if (stall_wait[1] && stall1_q != 16'hFFFF) stall1_q <= stall1_q + 16'd1;
    end
  end

  assign bus.stall0 = stall0_q;
  assign bus.stall1 = stall1_q;
`else
  assign bus.stall0 = 16'd0;
  assign bus.stall1 = 16'd0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: random requesters hold req until ack, sometimes dropping req mid-access.
module tb_mem_bus_arbiter;
  localparam int LATENCY  = 2;
  localparam int MAX_LOCK = 4;

  logic clk;
  logic rst_n;
  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.LATENCY(LATENCY), .MAX_LOCK(MAX_LOCK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural memory attached to the DUT memory port.
  bit [7:0] mem_arr [256];
  bit [7:0] ref_mem [256];

  function automatic logic [7:0] midx(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  assign bus.mem_rdata = mem_arr[midx(bus.mem_addr)];
  always @(posedge clk) if (bus.mem_enable && bus.mem_we) mem_arr[midx(bus.mem_addr)] <= bus.mem_wdata;

  // Transaction-level reference: m_left counts cycles left in the current transaction.
  int          m_left;
  bit          m_owner, m_rr, m_lock_prev, m_we;
  int          m_lock_run;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata, m_txn_rd;
  int unsigned m_stall [2];
  bit   [1:0]  pend;

  task automatic model_reset();
    m_left = 0; m_owner = 0; m_rr = 0; m_lock_prev = 0; m_we = 0;
    m_lock_run = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_txn_rd = 0;
    m_stall[0] = 0; m_stall[1] = 0;
  endtask

  task automatic model_edge();
    bit w, cl, gnt;
    gnt = (m_left == 0) && (bus.req != 2'b00);
    w = 0; cl = 0;
    if (gnt) begin
      if (bus.req == 2'b01) w = 0;
      else if (bus.req == 2'b10) w = 1;
      else if (m_lock_prev && bus.req[m_owner] && m_lock_run < MAX_LOCK) begin w = m_owner; cl = 1; end
      else w = m_rr;
    end
`ifdef ARB_STALL_COUNT_EN
    for (int n = 0; n < 2; n++)
      if (bus.req[n] && !(m_left > 0 && m_owner == 1'(n)) && !(gnt && w == 1'(n)) && m_stall[n] != 32'hFFFF)
        m_stall[n]++;
`endif
    if (gnt) begin
      if (cl && bus.lock[w]) m_lock_run++;
      else if (!cl && bus.req != 2'b11 && w == m_owner && bus.lock[w]) m_lock_run = m_lock_run;
      else m_lock_run = 0;
      m_owner = w; m_rr = !w; m_lock_prev = bus.lock[w];
      m_addr  = w ? bus.addr1 : bus.addr0;
      m_wdata = w ? bus.wdata1 : bus.wdata0;
      m_we    = bus.we[w];
      if (m_we) ref_mem[midx(m_addr)] = m_wdata;
      else      m_txn_rd = ref_mem[midx(m_addr)];
      m_left = LATENCY + 1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1 && !m_we) m_rdata = m_txn_rd;
    end
  endtask

  task automatic compare_outputs();
    logic [1:0] eack;
    eack = (m_left == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("ack", 32'(bus.ack), 32'(eack));
    chk("busy", 32'(bus.busy), 32'(m_left > 0));
    chk("mem_enable", 32'(bus.mem_enable), 32'(m_left > 1));
    chk("mem_we", 32'(bus.mem_we), 32'(m_left > 1 && m_we));
    chk("owner", 32'(bus.owner), 32'(m_owner));
    chk("rdata", 32'(bus.rdata), 32'(m_rdata));
    if (m_left > 1) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      if (m_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    end
    chk("stall0", 32'(bus.stall0), m_stall[0]);
    chk("stall1", 32'(bus.stall1), m_stall[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.lock = '0; bus.we = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    pend = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    rst_n = 1'b1;
  endtask

  // One isolated transaction from IDLE; returns cycles to ack and matching enable cycles.
  task automatic run_txn(input int p, input bit w, input logic [15:0] a, input logic [7:0] d,
                         output int lat, output int en);
    bit got;
    got = 0; lat = 99; en = 0;
    bus.we[p] = w; bus.lock[p] = 1'b0; bus.req[p] = 1'b1;
    if (p == 0) begin bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.addr1 = a; bus.wdata1 = d; end
    for (int i = 1; i <= 20 && !got; i++) begin
      step();
      if (bus.mem_enable && bus.mem_addr == a && bus.mem_we == w && (!w || bus.mem_wdata == d)) en++;
      if (bus.ack[p]) begin got = 1; lat = i; end
    end
    bus.req[p] = 1'b0;
    step();
  endtask

  task automatic drive_random();
    for (int n = 0; n < 2; n++) begin
      if (bus.ack[n]) pend[n] = 1'b0;
      if (!pend[n]) begin
        if ($urandom_range(0, 2) == 0) begin
          pend[n] = 1'b1;
          bus.req[n]  = 1'b1;
          bus.we[n]   = 1'($urandom_range(0, 1));
          bus.lock[n] = 1'($urandom_range(0, 1));
          if (n == 0) begin
            bus.addr0  = 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 3)) << 12);
            bus.wdata0 = 8'($urandom_range(0, 255));
          end else begin
            bus.addr1  = 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 3)) << 12);
            bus.wdata1 = 8'($urandom_range(0, 255));
          end
        end else begin
          bus.req[n] = 1'b0; bus.lock[n] = 1'b0;
        end
      end else if (bus.busy && bus.owner == 1'(n) && !bus.ack[n]) begin
        // Operands of a granted access may change freely; req may even drop.
        if ($urandom_range(0, 3) == 0) begin
          if (n == 0) begin bus.addr0 = 16'($urandom); bus.wdata0 = 8'($urandom); end
          else        begin bus.addr1 = 16'($urandom); bus.wdata1 = 8'($urandom); end
        end
        if ($urandom_range(0, 7) == 0) bus.req[n] = 1'b0;
      end
    end
  endtask

  initial begin
    int lat, en;
    int seq[$];
    rst_n = 1'b0;
    apply_reset();

    // Write A5 to 1234, read it back, then write 3C to 8000 leaving rdata alone.
    run_txn(0, 1'b1, 16'h1234, 8'hA5, lat, en);
    chk("wr1234_latency", 32'(lat), 32'(LATENCY + 1));
    run_txn(0, 1'b0, 16'h1234, 8'h00, lat, en);
    chk("rd1234_latency", 32'(lat), 32'(LATENCY + 1));
    chk("rd1234_enable_cycles", 32'(en), 32'(LATENCY));
    chk("rd1234_rdata", 32'(bus.rdata), 32'h A5);
    run_txn(0, 1'b1, 16'h8000, 8'h3C, lat, en);
    chk("wr8000_enable_cycles", 32'(en), 32'(LATENCY));
    chk("wr8000_rdata_held", 32'(bus.rdata), 32'hA5);
    run_txn(1, 1'b0, 16'h8000, 8'h00, lat, en);
    chk("dma_rd8000_rdata", 32'(bus.rdata), 32'h3C);

    // Unlocked tie from reset alternates CPU, DMA, CPU, DMA.
    apply_reset();
    bus.req = 2'b11;
    for (int i = 0; i < 60 && seq.size() < 4; i++) begin
      step();
      if (bus.ack[0]) seq.push_back(0);
      if (bus.ack[1]) seq.push_back(1);
    end
    chk("alt_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < 4 && i < seq.size(); i++) chk($sformatf("alt_grant%0d", i), 32'(seq[i]), 32'(i % 2));

    // Locked CPU against a waiting DMA: lock run is capped.
    apply_reset();
    seq.delete();
    bus.req = 2'b11; bus.lock = 2'b01;
    for (int i = 0; i < 120 && seq.size() < MAX_LOCK + 2; i++) begin
      step();
      if (bus.ack[0]) seq.push_back(0);
      if (bus.ack[1]) seq.push_back(1);
    end
    chk("lock_count", 32'(seq.size()), 32'(MAX_LOCK + 2));
    for (int i = 0; i < MAX_LOCK + 2 && i < seq.size(); i++)
      chk($sformatf("lock_grant%0d", i), 32'(seq[i]), 32'(i == MAX_LOCK + 1));

    // Reset during the second enable cycle abandons the access.
    apply_reset();
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 16'h0042;
    step();
    step();
    chk("mid_enable_before_reset", 32'(bus.mem_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_enable", 32'(bus.mem_enable), 32'd0);
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    chk("mid_reset_ack", 32'(bus.ack), 32'd0);
    model_reset();
    bus.req = 2'b11; bus.lock = 2'b00;
    @(posedge clk);
    #1;
    chk("in_reset_ack", 32'(bus.ack), 32'd0);
    rst_n = 1'b1;
    step();
    chk("tie_after_reset_owner", 32'(bus.owner), 32'd0);
    chk("tie_after_reset_busy", 32'(bus.busy), 32'd1);

    // DMA requests one cycle after a CPU grant.
    apply_reset();
    bus.req = 2'b01;
    step();
    bus.req[1] = 1'b1;
    for (int i = 0; i < 20 && !bus.ack[0]; i++) step();
    bus.req[0] = 1'b0;
    step();
    step();
`ifdef ARB_STALL_COUNT_EN
    chk("stall1_wait", 32'(bus.stall1), 32'd3);
`else
    chk("stall1_tied", 32'(bus.stall1), 32'd0);
`endif
    chk("stall0_none", 32'(bus.stall0), 32'd0);
    chk("dma_owner", 32'(bus.owner), 32'd1);

    // Randomized traffic.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      step();
      drive_random();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
